mt_func_ctl: RTL and testbench
==============================

// Module: mt_func_ctl
// PURPOSE
//  TM02 function controller for the MT (magtape) subsystem; directly upstream of the drive status register (DS).
//  Accepts GO writes to CS1, validates the function and launches transport operations.
//  Maintains the mtER error register consumed by DS. Generates mtGO (DS derives DRY = !mtGO) and the mtDRVCLR pulse.
// PARAMETERS
//  TOWIDTH   24        width of operation timeout counter
//  TOLIMIT   24'hFFFFFF cycles in RUN before OPI (operation incomplete) is declared
// PORTS
//  clk        in   1   clock
//  rst_n      in   1   reset; asynchronous, active-low
//  mtINIT     in   1   controller init; synchronous clear
//  mtWRCS1    in   1   one-cycle strobe: CPU write to CS1
//  mtDATAI    in   6   CS1 write data [5:1]=FUN, [0]=GO
//  mtWRREG    in   1   one-cycle strobe: CPU write to any other drive register
//  mtMOL      in   1   medium on-line
//  mtWRL      in   1   write lock
//  mtDONE     in   1   one-cycle strobe: transport finished current operation
//  mtSETERR   in   16  one-cycle error-set pulses from data path, mtER bit positions
//  mtGO       out  1   operation in progress
//  mtFUN      out  5   latched function of current/last accepted command
//  mtSTART    out  1   one-cycle pulse: transport begins mtFUN
//  mtABORT    out  1   one-cycle pulse: running operation cancelled
//  mtDRVCLR   out  1   one-cycle drive-clear pulse (to DS, data path)
//  mtER       out  16  error register
// BEHAVIOUR
//  Reset (rst_n=0, async): every output 0; state IDLE; timer 0.
//  mtINIT (sync): same values as reset; overrides all other inputs that cycle.
//  Function codes (FUN): NOP 0, UNLOAD 1, REWIND 3, DRVCLR 4, PRESET 8, ERASE 10, WTM 11, SPCF 12, SPCR 13,
//   WCHKF 20, WCHKR 23, WRF 24, RDF 28, RDR 31; all other codes illegal.
//   Write class = ERASE, WTM, WRF. Immediate class = NOP, DRVCLR, PRESET. All others are motion class.
//  mtER bits: 0 ILF, 1 ILR, 2 RMR, 11 NEF, 13 OPI, 14 UNS; every bit is also settable by the matching mtSETERR bit.
//  FSM: IDLE, CHECK, RUN.
//   IDLE: mtWRCS1 & GO=1 -> latch mtFUN, go to CHECK, mtGO=1 from the next cycle.
//    GO=0 writes are ignored. While mtER!=0, every FUN except DRVCLR is ignored (no state change).
//   CHECK (1 cycle), tested in priority order:
//    - DRVCLR: mtDRVCLR=1, -> IDLE.
//    - illegal FUN: set ILF, -> IDLE.
//    - NOP or PRESET: -> IDLE, no side effect.
//    - motion/write class with !mtMOL: set UNS, -> IDLE.
//    - write class with mtWRL: set NEF, -> IDLE.
//    - otherwise: mtSTART=1, timer cleared, -> RUN.
//   RUN: timer increments each cycle.
//    - mtDONE -> IDLE.
//    - timer==TOLIMIT: set OPI, mtABORT=1, -> IDLE.
//    - mtDONE and timeout in the same cycle: DONE wins, no OPI.
//  mtGO=1 exactly while state is CHECK or RUN; it drops in the cycle after the exit transition.
//  Busy rules (state!=IDLE):
//   - mtWRREG sets RMR.
//   - mtWRCS1 with GO=1 & FUN=DRVCLR: mtABORT=1 if in RUN, then mtDRVCLR=1, -> IDLE.
//   - any other mtWRCS1 sets RMR; the command is discarded.
//  mtDRVCLR pulse clears mtER the following cycle.
//  Clear vs set collision: a clear (DRVCLR/INIT) in the same cycle as any set (mtSETERR or internal) -> clear wins, mtER=0.
//  Error bits are sticky: they are set only by the events above and cleared only by DRVCLR or INIT.
//  mtSTART, mtABORT and mtDRVCLR are never asserted in the same cycle as each other, except mtABORT+mtDRVCLR on busy drive clear.
//  Latency: GO write to mtSTART = 2 cycles; GO write to mtGO rise = 1 cycle.
// STRUCTURE
//  Package mt_pkg holds:
//   - typedef enum logic[4:0] mtFUN_t with the codes above;
//   - localparams for mtER bit indices (ER_ILF ... ER_UNS);
//   - functions isWRITE(), isMOTION(), isLEGAL().
//  One sub-module, mt_optimer: TOWIDTH-bit counter with clr/en inputs and an expired output.
//  FSM and mtER register stay in mt_func_ctl.
// TESTING
//  1. Reset, MOL=1, WRL=0; write CS1=6'o71 (RDF+GO) -> mtGO rises +1 cycle, mtSTART pulse +2 cycles, mtFUN=28.
//     Then mtDONE -> mtGO=0 next cycle, mtER=0.
//  2. WRL=1; write 6'o61 (WRF) -> NEF (mtER=16'h0800), no mtSTART, mtGO high 1 cycle only.
//     Then write 6'o71 -> ignored. Then write 6'o11 -> mtDRVCLR pulse, mtER=0.
//  3. Write FUN=2 (6'o05) -> mtER=16'h0001 (ILF).
//     MOL=0 then SPCF (6'o31) after drive clear -> mtER=16'h4000 (UNS).
//  4. During RUN: pulse mtWRREG -> RMR (16'h0004) and the op continues.
//     Then write CS1=6'o11 -> mtABORT + mtDRVCLR the same cycle, mtGO=0, mtER=0.
//  5. TOLIMIT=16 override; start RDF with no mtDONE -> OPI (16'h2000) and mtABORT after 16 RUN cycles.
//     Repeat with mtDONE on the expiry cycle -> no OPI.
//  6. mtSETERR=16'h1000 coincident with mtDRVCLR clear -> mtER=0; rst_n low mid-RUN -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/mt_func_ctl_pkg.sv
// Shared types and helpers for the TM02 magtape function controller:
// function codes, FSM states, error-register bit positions and class decode.
package mt_pkg;

    typedef enum logic [4:0] {
        FUN_NOP    = 5'd0,
        FUN_UNLOAD = 5'd1,
        FUN_REWIND = 5'd3,
        FUN_DRVCLR = 5'd4,
        FUN_PRESET = 5'd8,
        FUN_ERASE  = 5'd10,
        FUN_WTM    = 5'd11,
        FUN_SPCF   = 5'd12,
        FUN_SPCR   = 5'd13,
        FUN_WCHKF  = 5'd20,
        FUN_WCHKR  = 5'd23,
        FUN_WRF    = 5'd24,
        FUN_RDF    = 5'd28,
        FUN_RDR    = 5'd31
    } mtFUN_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_RUN   = 2'd2
    } mt_state_t;

    localparam int ER_ILF = 0;
    localparam int ER_ILR = 1;
    localparam int ER_RMR = 2;
    localparam int ER_NEF = 11;
    localparam int ER_OPI = 13;
    localparam int ER_UNS = 14;

    function automatic logic isLEGAL(input logic [4:0] f);
        logic r;
        case (f)
            5'd0, 5'd1, 5'd3, 5'd4, 5'd8, 5'd10, 5'd11, 5'd12,
            5'd13, 5'd20, 5'd23, 5'd24, 5'd28, 5'd31: r = 1'b1;
            default:                                   r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic isWRITE(input logic [4:0] f);
        return (f == FUN_ERASE) || (f == FUN_WTM) || (f == FUN_WRF);
    endfunction

    function automatic logic isIMMED(input logic [4:0] f);
        return (f == FUN_NOP) || (f == FUN_DRVCLR) || (f == FUN_PRESET);
    endfunction

    // Motion class excludes write class; callers needing "moves tape" OR both.
    function automatic logic isMOTION(input logic [4:0] f);
        return isLEGAL(f) && !isIMMED(f) && !isWRITE(f);
    endfunction

endpackage

// File: rtl/mt_optimer.sv
// Operation timeout counter: cleared on clr, counts while en, and holds
// once it reaches TOLIMIT so expired stays asserted until cleared.
module mt_optimer #(
    parameter int                  TOWIDTH = 24,
    parameter logic [TOWIDTH-1:0]  TOLIMIT = 24'hFFFFFF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TOWIDTH-1:0] count_q;
    logic [TOWIDTH-1:0] count_d;

    assign expired = (count_q == TOLIMIT);

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (en && !expired)
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

endmodule

// File: rtl/mt_func_ctl.sv
// TM02 function controller: accepts CS1 GO writes, validates the function,
// launches transport operations and maintains the mtER error register.
module mt_func_ctl
    import mt_pkg::*;
#(
    parameter int                 TOWIDTH = 24,
    parameter logic [TOWIDTH-1:0] TOLIMIT = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mtINIT,
    input  logic        mtWRCS1,
    input  logic [5:0]  mtDATAI,
    input  logic        mtWRREG,
    input  logic        mtMOL,
    input  logic        mtWRL,
    input  logic        mtDONE,
    input  logic [15:0] mtSETERR,
    output logic        mtGO,
    output logic [4:0]  mtFUN,
    output logic        mtSTART,
    output logic        mtABORT,
    output logic        mtDRVCLR,
    output logic [15:0] mtER
);

    mt_state_t   state_q, state_d;
    logic [4:0]  fun_q, fun_d;
    logic        start_q, start_d;
    logic        abort_q, abort_d;
    logic        drvclr_q, drvclr_d;
    logic [15:0] er_q, er_d;
    logic [15:0] er_set;
    logic        tmr_clr, tmr_en, tmr_expired;

    logic       busy, go_wr, busy_clr, moves_tape, idle_accept;
    logic [4:0] wr_fun;

    assign busy        = (state_q != ST_IDLE);
    assign go_wr       = mtWRCS1 && mtDATAI[0];
    assign wr_fun      = mtDATAI[5:1];
    assign busy_clr    = busy && go_wr && (wr_fun == FUN_DRVCLR);
    assign moves_tape  = isMOTION(fun_q) || isWRITE(fun_q);
    // With an error latched, only a drive clear may get through.
    assign idle_accept = go_wr && ((er_q == '0) || (wr_fun == FUN_DRVCLR));

    mt_optimer #(
        .TOWIDTH (TOWIDTH),
        .TOLIMIT (TOLIMIT)
    ) u_optimer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            fun_q    <= '0;
            start_q  <= 1'b0;
            abort_q  <= 1'b0;
            drvclr_q <= 1'b0;
            er_q     <= '0;
        end else if (mtINIT) begin
            state_q  <= ST_IDLE;
            fun_q    <= '0;
            start_q  <= 1'b0;
            abort_q  <= 1'b0;
            drvclr_q <= 1'b0;
            er_q     <= '0;
        end else begin
            state_q  <= state_d;
            fun_q    <= fun_d;
            start_q  <= start_d;
            abort_q  <= abort_d;
            drvclr_q <= drvclr_d;
            er_q     <= er_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (idle_accept) state_d = ST_CHECK;
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (!busy_clr && isLEGAL(fun_q) && !isIMMED(fun_q) && mtMOL &&
                    !(isWRITE(fun_q) && mtWRL))
                    state_d = ST_RUN;
            end
            ST_RUN:   if (busy_clr || mtDONE || tmr_expired) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fun_d    = fun_q;
        start_d  = 1'b0;
        abort_d  = 1'b0;
        drvclr_d = 1'b0;
        er_set   = '0;
        tmr_clr  = mtINIT || (state_q == ST_CHECK);
        tmr_en   = (state_q == ST_RUN);
        mtGO     = busy;

        if (state_q == ST_IDLE && idle_accept)
            fun_d = wr_fun;

        if (busy && mtWRREG)
            er_set[ER_RMR] = 1'b1;
        if (busy && mtWRCS1 && !busy_clr)
            er_set[ER_RMR] = 1'b1;

        if (busy_clr) begin
            abort_d  = (state_q == ST_RUN);
            drvclr_d = 1'b1;
        end else if (state_q == ST_CHECK) begin
            if (fun_q == FUN_DRVCLR)
                drvclr_d = 1'b1;
            else if (!isLEGAL(fun_q))
                er_set[ER_ILF] = 1'b1;
            else if (isIMMED(fun_q))
                start_d = 1'b0;
            else if (moves_tape && !mtMOL)
                er_set[ER_UNS] = 1'b1;
            else if (isWRITE(fun_q) && mtWRL)
                er_set[ER_NEF] = 1'b1;
            else
                start_d = 1'b1;
        end else if (state_q == ST_RUN && !mtDONE && tmr_expired) begin
            er_set[ER_OPI] = 1'b1;
            abort_d        = 1'b1;
        end

        // A pending drive clear beats any simultaneous error set.
        er_d = drvclr_q ? '0 : (er_q | mtSETERR | er_set);
    end

    assign mtFUN    = fun_q;
    assign mtSTART  = start_q;
    assign mtABORT  = abort_q;
    assign mtDRVCLR = drvclr_q;
    assign mtER     = er_q;

endmodule

// File: tb/tb_mt_func_ctl.sv
// Directed bench for mt_func_ctl with a 16-cycle operation timeout.
module tb_mt_func_ctl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mtINIT = 1'b0;
    logic        mtWRCS1 = 1'b0;
    logic [5:0]  mtDATAI = '0;
    logic        mtWRREG = 1'b0;
    logic        mtMOL = 1'b1;
    logic        mtWRL = 1'b0;
    logic        mtDONE = 1'b0;
    logic [15:0] mtSETERR = '0;
    logic        mtGO;
    logic [4:0]  mtFUN;
    logic        mtSTART;
    logic        mtABORT;
    logic        mtDRVCLR;
    logic [15:0] mtER;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mt_func_ctl #(.TOWIDTH(24), .TOLIMIT(24'd16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mtINIT   (mtINIT),
        .mtWRCS1  (mtWRCS1),
        .mtDATAI  (mtDATAI),
        .mtWRREG  (mtWRREG),
        .mtMOL    (mtMOL),
        .mtWRL    (mtWRL),
        .mtDONE   (mtDONE),
        .mtSETERR (mtSETERR),
        .mtGO     (mtGO),
        .mtFUN    (mtFUN),
        .mtSTART  (mtSTART),
        .mtABORT  (mtABORT),
        .mtDRVCLR (mtDRVCLR),
        .mtER     (mtER)
    );

    // Returns at the negedge after the strobe was sampled.
    task automatic wr_cs1(input logic [5:0] v);
        @(negedge clk);
        mtWRCS1 = 1'b1;
        mtDATAI = v;
        @(negedge clk);
        mtWRCS1 = 1'b0;
        mtDATAI = '0;
        $display("cs1 write %o", v);
    endtask

    task automatic drive_clear();
        wr_cs1(6'o11);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({mtGO, mtFUN, mtSTART, mtABORT, mtDRVCLR, mtER} !== 25'd0) begin
            $display("FAIL reset_outputs got=%h want=0", {mtGO, mtFUN, mtSTART, mtABORT, mtDRVCLR, mtER});
            errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read_op();
        mtMOL = 1'b1; mtWRL = 1'b0;
        wr_cs1(6'o71);
        checks++;
        if (mtGO !== 1'b1 || mtSTART !== 1'b0) begin
            $display("FAIL rdf_go_rise go=%b start=%b want go=1 start=0", mtGO, mtSTART);
            errors++;
        end
        checks++;
        if (mtFUN !== 5'd28) begin
            $display("FAIL rdf_fun got=%0d want=28", mtFUN);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (mtSTART !== 1'b1 || mtGO !== 1'b1) begin
            $display("FAIL rdf_start start=%b go=%b want 1 1", mtSTART, mtGO);
            errors++;
        end
        mtDONE = 1'b1;
        @(negedge clk);
        mtDONE = 1'b0;
        checks++;
        if (mtGO !== 1'b0 || mtER !== 16'h0000 || mtSTART !== 1'b0) begin
            $display("FAIL rdf_done go=%b er=%h start=%b want 0 0000 0", mtGO, mtER, mtSTART);
            errors++;
        end
    endtask

    task automatic test_write_lock();
        mtWRL = 1'b1;
        wr_cs1(6'o61);
        checks++;
        if (mtGO !== 1'b1) begin
            $display("FAIL wrf_go got=%b want=1", mtGO);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (mtER !== 16'h0800 || mtGO !== 1'b0 || mtSTART !== 1'b0) begin
            $display("FAIL wrf_nef er=%h go=%b start=%b want 0800 0 0", mtER, mtGO, mtSTART);
            errors++;
        end
        wr_cs1(6'o71);
        checks++;
        if (mtGO !== 1'b0 || mtFUN !== 5'd24) begin
            $display("FAIL err_ignore go=%b fun=%0d want 0 24", mtGO, mtFUN);
            errors++;
        end
        wr_cs1(6'o11);
        @(negedge clk);
        checks++;
        if (mtDRVCLR !== 1'b1 || mtGO !== 1'b0 || mtER !== 16'h0800) begin
            $display("FAIL drvclr_pulse clr=%b go=%b er=%h want 1 0 0800", mtDRVCLR, mtGO, mtER);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (mtDRVCLR !== 1'b0 || mtER !== 16'h0000) begin
            $display("FAIL drvclr_clear clr=%b er=%h want 0 0000", mtDRVCLR, mtER);
            errors++;
        end
        mtWRL = 1'b0;
    endtask

    task automatic test_illegal_unsafe();
        wr_cs1(6'o05);
        @(negedge clk);
        checks++;
        if (mtER !== 16'h0001) begin
            $display("FAIL ilf got=%h want=0001", mtER);
            errors++;
        end
        drive_clear();
        mtMOL = 1'b0;
        wr_cs1(6'o31);
        @(negedge clk);
        checks++;
        if (mtER !== 16'h4000 || mtSTART !== 1'b0) begin
            $display("FAIL uns er=%h start=%b want 4000 0", mtER, mtSTART);
            errors++;
        end
        drive_clear();
        mtMOL = 1'b1;
    endtask

    task automatic test_busy();
        wr_cs1(6'o71);
        @(negedge clk);
        mtWRREG = 1'b1;
        @(negedge clk);
        mtWRREG = 1'b0;
        checks++;
        if (mtER !== 16'h0004 || mtGO !== 1'b1) begin
            $display("FAIL rmr er=%h go=%b want 0004 1", mtER, mtGO);
            errors++;
        end
        wr_cs1(6'o11);
        checks++;
        if (mtABORT !== 1'b1 || mtDRVCLR !== 1'b1 || mtGO !== 1'b0) begin
            $display("FAIL busy_clr abort=%b clr=%b go=%b want 1 1 0", mtABORT, mtDRVCLR, mtGO);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (mtER !== 16'h0000 || mtABORT !== 1'b0) begin
            $display("FAIL busy_clr_er er=%h abort=%b want 0000 0", mtER, mtABORT);
            errors++;
        end
    endtask

    task automatic test_timeout();
        wr_cs1(6'o71);
        repeat (17) @(negedge clk);
        checks++;
        if (mtGO !== 1'b1 || mtABORT !== 1'b0) begin
            $display("FAIL to_early go=%b abort=%b want 1 0", mtGO, mtABORT);
            errors++;
        end
        @(negedge clk);
        checks++;
        if (mtER !== 16'h2000 || mtABORT !== 1'b1 || mtGO !== 1'b0) begin
            $display("FAIL opi er=%h abort=%b go=%b want 2000 1 0", mtER, mtABORT, mtGO);
            errors++;
        end
        drive_clear();
        wr_cs1(6'o71);
        repeat (17) @(negedge clk);
        mtDONE = 1'b1;
        @(negedge clk);
        mtDONE = 1'b0;
        checks++;
        if (mtER !== 16'h0000 || mtABORT !== 1'b0 || mtGO !== 1'b0) begin
            $display("FAIL done_wins er=%h abort=%b go=%b want 0000 0 0", mtER, mtABORT, mtGO);
            errors++;
        end
    endtask

    task automatic test_collision_and_reset();
        mtSETERR = 16'h1000;
        @(negedge clk);
        mtSETERR = '0;
        checks++;
        if (mtER !== 16'h1000) begin
            $display("FAIL seterr got=%h want=1000", mtER);
            errors++;
        end
        wr_cs1(6'o11);
        @(negedge clk);
        mtSETERR = 16'h1000;
        @(negedge clk);
        mtSETERR = '0;
        checks++;
        if (mtER !== 16'h0000) begin
            $display("FAIL clr_wins got=%h want=0000", mtER);
            errors++;
        end
        wr_cs1(6'o71);
        mtINIT = 1'b1;
        @(negedge clk);
        mtINIT = 1'b0;
        checks++;
        if (mtGO !== 1'b0 || mtFUN !== 5'd0) begin
            $display("FAIL init go=%b fun=%0d want 0 0", mtGO, mtFUN);
            errors++;
        end
        wr_cs1(6'o71);
        @(negedge clk);
        mtWRREG = 1'b1;
        @(negedge clk);
        mtWRREG = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mtGO, mtFUN, mtSTART, mtABORT, mtDRVCLR, mtER} !== 25'd0) begin
            $display("FAIL async_reset got=%h want=0", {mtGO, mtFUN, mtSTART, mtABORT, mtDRVCLR, mtER});
            errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_op();
        test_write_lock();
        test_illegal_unsafe();
        test_busy();
        test_timeout();
        test_collision_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
